// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_stage
//  Purpose  : RV32I execute stage. Forwards MEM/WB results, selects the ALU
//             operands and computes the ALU result plus a registered copy.
//  Revision : 1.0  initial release
// ============================================================================
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      ALUCode_ex,
    input  logic            ALUSrcA_ex,
    input  logic [1:0]      ALUSrcB_ex,
    input  logic [XLEN-1:0] Imm_ex,
    input  logic [4:0]      rs1Addr_ex,
    input  logic [4:0]      rs2Addr_ex,
    input  logic [XLEN-1:0] rs1Data_ex,
    input  logic [XLEN-1:0] rs2Data_ex,
    input  logic [XLEN-1:0] PC_ex,
    input  logic [XLEN-1:0] RegWriteData_wb,
    input  logic [XLEN-1:0] ALUResult_mem,
    input  logic [4:0]      rdAddr_mem,
    input  logic [4:0]      rdAddr_wb,
    input  logic            RegWrite_mem,
    input  logic            RegWrite_wb,
    output logic [XLEN-1:0] ALUResult_ex,
    output logic [XLEN-1:0] MemWriteData_ex,
    output logic [XLEN-1:0] ALU_A,
    output logic [XLEN-1:0] ALU_B,
    output logic [XLEN-1:0] ALUResult_q
);

    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_SUB  = 4'd1;
    localparam logic [3:0] c_ALU_LUI  = 4'd2;
    localparam logic [3:0] c_ALU_AND  = 4'd3;
    localparam logic [3:0] c_ALU_XOR  = 4'd4;
    localparam logic [3:0] c_ALU_OR   = 4'd5;
    localparam logic [3:0] c_ALU_SLL  = 4'd6;
    localparam logic [3:0] c_ALU_SRL  = 4'd7;
    localparam logic [3:0] c_ALU_SRA  = 4'd8;
    localparam logic [3:0] c_ALU_SLT  = 4'd9;
    localparam logic [3:0] c_ALU_SLTU = 4'd10;

    logic            w_mem_hit_a;
    logic            w_wb_hit_a;
    logic            w_mem_hit_b;
    logic            w_wb_hit_b;
    logic [XLEN-1:0] w_fwd_a;
    logic [XLEN-1:0] w_fwd_b;
    logic [4:0]      w_shamt;
    logic            w_slt;
    logic            w_sltu;

    // x0 is hard-wired zero, so a pending write to it must never be forwarded.
    assign w_mem_hit_a = RegWrite_mem && (rdAddr_mem != 5'd0) && (rdAddr_mem == rs1Addr_ex);
    assign w_wb_hit_a  = RegWrite_wb  && (rdAddr_wb  != 5'd0) && (rdAddr_wb  == rs1Addr_ex);
    assign w_mem_hit_b = RegWrite_mem && (rdAddr_mem != 5'd0) && (rdAddr_mem == rs2Addr_ex);
    assign w_wb_hit_b  = RegWrite_wb  && (rdAddr_wb  != 5'd0) && (rdAddr_wb  == rs2Addr_ex);

    // MEM is checked first: it holds the younger write to the same register.
    assign w_fwd_a = w_mem_hit_a ? ALUResult_mem :
                     w_wb_hit_a  ? RegWriteData_wb : rs1Data_ex;
    assign w_fwd_b = w_mem_hit_b ? ALUResult_mem :
                     w_wb_hit_b  ? RegWriteData_wb : rs2Data_ex;

    assign MemWriteData_ex = w_fwd_b;
    assign ALU_A           = ALUSrcA_ex ? PC_ex : w_fwd_a;

    always_comb begin
        ALU_B = '0;
        case (ALUSrcB_ex)
            2'b00:   ALU_B = w_fwd_b;
            2'b01:   ALU_B = Imm_ex;
            2'b10:   ALU_B = XLEN'(4);
            default: ALU_B = '0;
        endcase
    end

    assign w_shamt = ALU_B[4:0];
    assign w_slt   = $signed(ALU_A) < $signed(ALU_B);
    assign w_sltu  = ALU_A < ALU_B;

    always_comb begin
        ALUResult_ex = '0;
        case (ALUCode_ex)
            c_ALU_ADD:  ALUResult_ex = ALU_A + ALU_B;
            c_ALU_SUB:  ALUResult_ex = ALU_A - ALU_B;
            c_ALU_LUI:  ALUResult_ex = ALU_B;
            c_ALU_AND:  ALUResult_ex = ALU_A & ALU_B;
            c_ALU_XOR:  ALUResult_ex = ALU_A ^ ALU_B;
            c_ALU_OR:   ALUResult_ex = ALU_A | ALU_B;
            c_ALU_SLL:  ALUResult_ex = ALU_A << w_shamt;
            c_ALU_SRL:  ALUResult_ex = ALU_A >> w_shamt;
            c_ALU_SRA:  ALUResult_ex = $unsigned($signed(ALU_A) >>> w_shamt);
            c_ALU_SLT:  ALUResult_ex = {{(XLEN-1){1'b0}}, w_slt};
            c_ALU_SLTU: ALUResult_ex = {{(XLEN-1){1'b0}}, w_sltu};
            default:    ALUResult_ex = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUResult_q <= '0;
        end else begin
            ALUResult_q <= ALUResult_ex;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_stage
//  Purpose  : Self-checking bench for ex_stage: directed cases plus random
//             vectors against a behavioural reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_stage;

    logic        clk;
    logic        rst_n;
    logic [3:0]  ALUCode_ex;
    logic        ALUSrcA_ex;
    logic [1:0]  ALUSrcB_ex;
    logic [31:0] Imm_ex;
    logic [4:0]  rs1Addr_ex;
    logic [4:0]  rs2Addr_ex;
    logic [31:0] rs1Data_ex;
    logic [31:0] rs2Data_ex;
    logic [31:0] PC_ex;
    logic [31:0] RegWriteData_wb;
    logic [31:0] ALUResult_mem;
    logic [4:0]  rdAddr_mem;
    logic [4:0]  rdAddr_wb;
    logic        RegWrite_mem;
    logic        RegWrite_wb;
    logic [31:0] ALUResult_ex;
    logic [31:0] MemWriteData_ex;
    logic [31:0] ALU_A;
    logic [31:0] ALU_B;
    logic [31:0] ALUResult_q;

    int errors = 0;
    int checks = 0;

    ex_stage #(.XLEN(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ALUCode_ex      (ALUCode_ex),
        .ALUSrcA_ex      (ALUSrcA_ex),
        .ALUSrcB_ex      (ALUSrcB_ex),
        .Imm_ex          (Imm_ex),
        .rs1Addr_ex      (rs1Addr_ex),
        .rs2Addr_ex      (rs2Addr_ex),
        .rs1Data_ex      (rs1Data_ex),
        .rs2Data_ex      (rs2Data_ex),
        .PC_ex           (PC_ex),
        .RegWriteData_wb (RegWriteData_wb),
        .ALUResult_mem   (ALUResult_mem),
        .rdAddr_mem      (rdAddr_mem),
        .rdAddr_wb       (rdAddr_wb),
        .RegWrite_mem    (RegWrite_mem),
        .RegWrite_wb     (RegWrite_wb),
        .ALUResult_ex    (ALUResult_ex),
        .MemWriteData_ex (MemWriteData_ex),
        .ALU_A           (ALU_A),
        .ALU_B           (ALU_B),
        .ALUResult_q     (ALUResult_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: newest in-flight producer of a register, x0 excluded.
    function automatic logic [31:0] ref_operand(input logic [4:0] addr, input logic [31:0] rf);
        if (addr == 5'd0)                             return rf;
        if (RegWrite_mem && rdAddr_mem == addr)       return ALUResult_mem;
        if (RegWrite_wb && rdAddr_wb == addr)         return RegWriteData_wb;
        return rf;
    endfunction

    function automatic logic [31:0] ref_b();
        case (ALUSrcB_ex)
            2'b00:   return ref_operand(rs2Addr_ex, rs2Data_ex);
            2'b01:   return Imm_ex;
            2'b10:   return 32'd4;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        int unsigned s;
        logic [31:0] fill;
        s = b % 32;
        fill = a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0;
        case (code)
            4'd0:    return a + b;
            4'd1:    return a + ~b + 32'd1;
            4'd2:    return b;
            4'd3:    return a & b;
            4'd4:    return a ^ b;
            4'd5:    return a | b;
            4'd6:    return 32'(64'(a) * (64'd1 << s));
            4'd7:    return 32'(a / (33'd1 << s));
            4'd8:    return (a >> s) | fill;
            4'd9:    return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd10:   return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic clear_inputs();
        ALUCode_ex = 4'd0; ALUSrcA_ex = 1'b0; ALUSrcB_ex = 2'b00; Imm_ex = 32'd0;
        rs1Addr_ex = 5'd0; rs2Addr_ex = 5'd0; rs1Data_ex = 32'd0; rs2Data_ex = 32'd0;
        PC_ex = 32'd0; RegWriteData_wb = 32'd0; ALUResult_mem = 32'd0;
        rdAddr_mem = 5'd0; rdAddr_wb = 5'd0; RegWrite_mem = 1'b0; RegWrite_wb = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        ALUCode_ex = 4'd1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ALUResult_q !== 32'd0) begin errors++; $display("FAIL reset_q: got %h want %h", ALUResult_q, 32'd0); end
        checks++;
        if (ALUResult_ex !== 32'd0) begin errors++; $display("FAIL reset_sub_res: got %h want %h", ALUResult_ex, 32'd0); end
        checks++;
        if (ALU_A !== 32'd0 || ALU_B !== 32'd0) begin errors++; $display("FAIL reset_ops: got A=%h B=%h want 0", ALU_A, ALU_B); end
        checks++;
        if (MemWriteData_ex !== 32'd0) begin errors++; $display("FAIL reset_mwd: got %h want 0", MemWriteData_ex); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add_imm();
        @(negedge clk);
        clear_inputs();
        rs1Data_ex = 32'd5; Imm_ex = 32'd7; ALUSrcB_ex = 2'b01; ALUCode_ex = 4'd0;
        #1;
        checks++;
        if (ALU_B !== 32'd7) begin errors++; $display("FAIL addi_b: got %h want %h", ALU_B, 32'd7); end
        checks++;
        if (ALUResult_ex !== 32'd12) begin errors++; $display("FAIL addi_res: got %h want %h", ALUResult_ex, 32'd12); end
        @(posedge clk); #1;
        checks++;
        if (ALUResult_q !== 32'd12) begin errors++; $display("FAIL addi_q: got %h want %h", ALUResult_q, 32'd12); end
    endtask

    task automatic test_forward_priority();
        @(negedge clk);
        clear_inputs();
        rs1Addr_ex = 5'd3; rdAddr_mem = 5'd3; rdAddr_wb = 5'd3;
        RegWrite_mem = 1'b1; RegWrite_wb = 1'b1;
        ALUResult_mem = 32'hAA; RegWriteData_wb = 32'hBB; rs1Data_ex = 32'h11;
        #1;
        checks++;
        if (ALU_A !== 32'hAA) begin errors++; $display("FAIL fwd_mem_prio: got %h want %h", ALU_A, 32'hAA); end
        RegWrite_mem = 1'b0;
        #1;
        checks++;
        if (ALU_A !== 32'hBB) begin errors++; $display("FAIL fwd_wb: got %h want %h", ALU_A, 32'hBB); end
        RegWrite_wb = 1'b0;
        #1;
        checks++;
        if (ALU_A !== 32'h11) begin errors++; $display("FAIL fwd_none: got %h want %h", ALU_A, 32'h11); end
    endtask

    task automatic test_x0();
        @(negedge clk);
        clear_inputs();
        rs2Addr_ex = 5'd0; rdAddr_mem = 5'd0; RegWrite_mem = 1'b1;
        ALUResult_mem = 32'd9; rs2Data_ex = 32'd4; ALUSrcB_ex = 2'b01;
        #1;
        checks++;
        if (MemWriteData_ex !== 32'd4) begin errors++; $display("FAIL x0_nofwd: got %h want %h", MemWriteData_ex, 32'd4); end
        rs2Addr_ex = 5'd7; rdAddr_mem = 5'd7;
        #1;
        checks++;
        if (MemWriteData_ex !== 32'd9) begin errors++; $display("FAIL store_fwd: got %h want %h", MemWriteData_ex, 32'd9); end
    endtask

    task automatic test_pc_shift();
        @(negedge clk);
        clear_inputs();
        ALUSrcA_ex = 1'b1; PC_ex = 32'h100; ALUSrcB_ex = 2'b10; ALUCode_ex = 4'd0;
        #1;
        checks++;
        if (ALUResult_ex !== 32'h104) begin errors++; $display("FAIL pc_plus4: got %h want %h", ALUResult_ex, 32'h104); end
        ALUSrcA_ex = 1'b0; rs1Data_ex = 32'h8000_0000; ALUSrcB_ex = 2'b01; Imm_ex = 32'd4; ALUCode_ex = 4'd8;
        #1;
        checks++;
        if (ALUResult_ex !== 32'hF800_0000) begin errors++; $display("FAIL sra: got %h want %h", ALUResult_ex, 32'hF800_0000); end
        rs1Data_ex = 32'hFFFF_FFFF; Imm_ex = 32'd1; ALUCode_ex = 4'd10;
        #1;
        checks++;
        if (ALUResult_ex !== 32'd0) begin errors++; $display("FAIL sltu: got %h want %h", ALUResult_ex, 32'd0); end
        ALUCode_ex = 4'd9;
        #1;
        checks++;
        if (ALUResult_ex !== 32'd1) begin errors++; $display("FAIL slt: got %h want %h", ALUResult_ex, 32'd1); end
        ALUSrcB_ex = 2'b11; ALUCode_ex = 4'd5;
        #1;
        checks++;
        if (ALU_B !== 32'd0 || ALUResult_ex !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL srcb_zero: got B=%h res=%h want B=0 res=ffffffff", ALU_B, ALUResult_ex);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        clear_inputs();
        rs1Data_ex = 32'd5; Imm_ex = 32'd7; ALUSrcB_ex = 2'b01;
        @(posedge clk); #1;
        checks++;
        if (ALUResult_q !== 32'd12) begin errors++; $display("FAIL areset_pre: got %h want %h", ALUResult_q, 32'd12); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (ALUResult_q !== 32'd0) begin errors++; $display("FAIL areset_q: got %h want %h", ALUResult_q, 32'd0); end
        checks++;
        if (ALUResult_ex !== 32'd12) begin errors++; $display("FAIL areset_comb: got %h want %h", ALUResult_ex, 32'd12); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] exp_a, exp_b, exp_res, exp_mwd;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            ALUCode_ex      = 4'($urandom_range(0, 15));
            ALUSrcA_ex      = 1'($urandom);
            ALUSrcB_ex      = 2'($urandom);
            Imm_ex          = $urandom;
            rs1Addr_ex      = 5'($urandom_range(0, 3));
            rs2Addr_ex      = 5'($urandom_range(0, 3));
            rs1Data_ex      = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            rs2Data_ex      = $urandom;
            PC_ex           = $urandom;
            RegWriteData_wb = $urandom;
            ALUResult_mem   = $urandom;
            rdAddr_mem      = 5'($urandom_range(0, 3));
            rdAddr_wb       = 5'($urandom_range(0, 3));
            RegWrite_mem    = 1'($urandom);
            RegWrite_wb     = 1'($urandom);
            #1;
            exp_a   = ALUSrcA_ex ? PC_ex : ref_operand(rs1Addr_ex, rs1Data_ex);
            exp_b   = ref_b();
            exp_mwd = ref_operand(rs2Addr_ex, rs2Data_ex);
            exp_res = ref_alu(ALUCode_ex, exp_a, exp_b);
            checks++;
            if (ALU_A !== exp_a) begin errors++; $display("FAIL rnd_a[%0d]: got %h want %h", i, ALU_A, exp_a); end
            checks++;
            if (ALU_B !== exp_b) begin errors++; $display("FAIL rnd_b[%0d]: got %h want %h", i, ALU_B, exp_b); end
            checks++;
            if (MemWriteData_ex !== exp_mwd) begin errors++; $display("FAIL rnd_mwd[%0d]: got %h want %h", i, MemWriteData_ex, exp_mwd); end
            checks++;
            if (ALUResult_ex !== exp_res) begin
                errors++; $display("FAIL rnd_res[%0d]: code=%0d A=%h B=%h got %h want %h", i, ALUCode_ex, exp_a, exp_b, ALUResult_ex, exp_res);
            end
            @(posedge clk); #1;
            checks++;
            if (ALUResult_q !== exp_res) begin errors++; $display("FAIL rnd_q[%0d]: got %h want %h", i, ALUResult_q, exp_res); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_add_imm();
        test_forward_priority();
        test_x0();
        test_pc_shift();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
